// File: rtl/stop_matrix_ctrl.sv
// Sequencer for the 16x16 block matrix-multiply core: streams blocks A and B from a
// source BRAM into the core, waits out the compute phase, then drains results to a destination BRAM.
module stop_matrix_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int BLOCK_SIZE     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int WORDS          = BLOCK_SIZE * BLOCK_SIZE / 4,
  parameter int COMPUTE_CYCLES = BLOCK_SIZE ** 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   a_base,
  input  logic [ADDR_WIDTH-1:0]   b_base,
  input  logic [ADDR_WIDTH-1:0]   c_base,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    src_en,
  output logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [4*DATA_WIDTH-1:0] src_rdata,
  output logic                    dst_we,
  output logic [ADDR_WIDTH-1:0]   dst_addr,
  output logic [4*DATA_WIDTH-1:0] dst_wdata,
  output logic                    core_rst_n,
  output logic                    core_valid,
  output logic [4*DATA_WIDTH-1:0] core_data,
  input  logic                    core_o_valid,
  input  logic [2*DATA_WIDTH-1:0] core_result0,
  input  logic [2*DATA_WIDTH-1:0] core_result1
);

  localparam int LOADS   = 2 * WORDS;
  localparam int PAIRS   = BLOCK_SIZE * BLOCK_SIZE / 2;
  localparam int CNT_MAX = (COMPUTE_CYCLES > LOADS) ? COMPUTE_CYCLES : LOADS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WIDX_W  = $clog2(WORDS);
  localparam int DIDX_W  = $clog2(PAIRS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   a_base_q, b_base_q, c_base_q;
  logic                    ld_vld_q;
  logic                    wr_q;
  logic [DIDX_W-1:0]       wr_idx_q;
  logic                    err_q;

  logic                    load_rd;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  // One phase counter is shared by LOAD, COMPUTE and DRAIN; each phase restarts it at zero.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // The extra count lets the last B word, read one cycle earlier, reach the core.
        if (cnt_q == CNT_W'(LOADS)) begin
          cnt_d   = '0;
          state_d = S_COMPUTE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == CNT_W'(COMPUTE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(PAIRS - 1)) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Reads cover A words 0..WORDS-1 then B words 0..WORDS-1; address arithmetic wraps naturally.
  always_comb begin
    load_rd = (state_q == S_LOAD) && (cnt_q < CNT_W'(LOADS));
    rd_addr = (cnt_q[WIDX_W] ? b_base_q : a_base_q) + ADDR_WIDTH'(cnt_q[WIDX_W-1:0]);
  end

  // Strobes are gated by reset so an abort stops BRAM traffic in the very cycle it is raised.
  always_comb begin
    busy       = (state_q inside {S_CLR, S_LOAD, S_COMPUTE, S_DRAIN});
    done       = (state_q == S_FIN);
    err        = err_q;
    src_en     = load_rd & ~reset;
    src_addr   = load_rd ? rd_addr : '0;
    core_rst_n = ~reset & (state_q != S_CLR);
    core_valid = (ld_vld_q | (state_q == S_DRAIN)) & ~reset;
    core_data  = ld_vld_q ? src_rdata : '0;
    dst_we     = wr_q & ~reset;
    dst_addr   = wr_q ? (c_base_q + ADDR_WIDTH'(wr_idx_q)) : '0;
    dst_wdata  = wr_q ? {core_result1, core_result0} : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      ld_vld_q <= 1'b0;
      wr_q     <= 1'b0;
      wr_idx_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_vld_q <= load_rd;
      wr_q     <= (state_q == S_DRAIN);
      if (state_q == S_DRAIN) wr_idx_q <= cnt_q[DIDX_W-1:0];

      if (state_q == S_IDLE && start) begin
        a_base_q <= a_base;
        b_base_q <= b_base;
        c_base_q <= c_base;
        err_q    <= 1'b0;
      end else if (wr_q && (wr_idx_q != DIDX_W'(PAIRS - 1)) && !core_o_valid) begin
        // The core drops o_valid on its final pair, so that write is exempt.
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stop_matrix_ctrl.sv
// Directed bench for stop_matrix_ctrl: BRAM models, a behavioural core stub and
// hand-computed or reference-model expectations for every destination word.
module tb_stop_matrix_ctrl;

  localparam int AW      = 10;
  localparam int LAT     = 4355;
  localparam int TIMEOUT = 6000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] a_base = '0, b_base = '0, c_base = '0;
  logic          busy, done, err;
  logic          src_en;
  logic [AW-1:0] src_addr;
  logic [31:0]   src_rdata = '0;
  logic          dst_we;
  logic [AW-1:0] dst_addr;
  logic [31:0]   dst_wdata;
  logic          core_rst_n, core_valid;
  logic [31:0]   core_data;
  logic          core_o_valid = 1'b0;
  logic [15:0]   core_result0 = '0, core_result1 = '0;

  always #5 clk = ~clk;

  stop_matrix_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done), .err(err),
    .src_en(src_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .core_rst_n(core_rst_n), .core_valid(core_valid), .core_data(core_data),
    .core_o_valid(core_o_valid), .core_result0(core_result0), .core_result1(core_result1)
  );

  // Source BRAM (read latency 1) and destination BRAM with traffic counters.
  logic [31:0] src_mem [1024];
  logic [31:0] dst_mem [1024];
  logic        clr_dst = 1'b0;
  int          rd_count = 0, wr_count = 0, done_count = 0;

  always @(posedge clk) if (src_en) src_rdata <= src_mem[src_addr];

  always @(posedge clk) begin
    if (clr_dst) foreach (dst_mem[i]) dst_mem[i] = 32'hDEAD_BEEF;
    if (src_en) rd_count++;
    if (dst_we) begin
      dst_mem[dst_addr] = dst_wdata;
      wr_count++;
    end
    if (done) done_count++;
  end

  // Core stub: takes 128 words, then answers each drain strobe with the next result pair.
  logic [31:0] a_w [64];
  logic [31:0] b_w [64];
  int          in_cnt = 0, out_cnt = 0;
  logic        fault5 = 1'b0;

  function automatic logic [7:0] stub_byte(input bit is_b, input int e);
    logic [31:0] w;
    w = is_b ? b_w[e/4] : a_w[e/4];
    return w[8*(e%4) +: 8];
  endfunction

  function automatic logic [15:0] stub_elem(input int idx);
    logic [15:0] acc;
    acc = '0;
    for (int k = 0; k < 16; k++)
      acc += 16'(stub_byte(1'b0, (idx/16)*16 + k)) * 16'(stub_byte(1'b1, k*16 + idx%16));
    return acc;
  endfunction

  always @(posedge clk) begin
    if (!core_rst_n) begin
      in_cnt <= 0; out_cnt <= 0; core_o_valid <= 1'b0;
      core_result0 <= '0; core_result1 <= '0;
    end else if (core_valid) begin
      if (in_cnt < 128) begin
        if (in_cnt < 64) a_w[in_cnt] <= core_data;
        else             b_w[in_cnt-64] <= core_data;
        in_cnt <= in_cnt + 1;
        core_o_valid <= 1'b0;
      end else begin
        core_result0 <= stub_elem(2*out_cnt);
        core_result1 <= stub_elem(2*out_cnt + 1);
        core_o_valid <= (out_cnt != 127) && !(fault5 && out_cnt == 5);
        out_cnt <= out_cnt + 1;
      end
    end else begin
      core_o_valid <= 1'b0;
    end
  end

  // Independent reference computed straight from the source memory image.
  function automatic logic [7:0] src_byte(input logic [AW-1:0] base, input int e);
    logic [AW-1:0] addr;
    logic [31:0]   w;
    addr = base + AW'(e/4);
    w = src_mem[addr];
    return w[8*(e%4) +: 8];
  endfunction

  function automatic logic [15:0] ref_elem(input logic [AW-1:0] a, input logic [AW-1:0] b, input int idx);
    logic [15:0] acc;
    acc = '0;
    for (int k = 0; k < 16; k++)
      acc += 16'(src_byte(a, (idx/16)*16 + k)) * 16'(src_byte(b, k*16 + idx%16));
    return acc;
  endfunction

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 identity, 1 ramp (e mod 256), 2 all 0xFF, 3 random bytes
  task automatic fill(input logic [AW-1:0] base, input int kind);
    for (int w = 0; w < 64; w++) begin
      logic [31:0]   word;
      logic [AW-1:0] addr;
      word = '0;
      for (int k = 0; k < 4; k++) begin
        int e;
        logic [7:0] v;
        e = 4*w + k;
        case (kind)
          0:       v = (e/16 == e%16) ? 8'd1 : 8'd0;
          1:       v = 8'(e);
          2:       v = 8'hFF;
          default: v = 8'($urandom_range(0, 255));
        endcase
        word[8*k +: 8] = v;
      end
      addr = base + AW'(w);
      src_mem[addr] = word;
    end
  endtask

  task automatic clear_dst();
    clr_dst = 1'b1;
    tick();
    clr_dst = 1'b0;
  endtask

  // Start is accepted on the next edge; bases are then scrambled to prove they were latched.
  task automatic start_job(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    a_base = a; b_base = b; c_base = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_base = ~a; b_base = ~b; c_base = ~c;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < TIMEOUT) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_job(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] c, input logic fault);
    int lat, rd0, wr0, dn0;
    clear_dst();
    fault5 = fault;
    rd0 = rd_count; wr0 = wr_count; dn0 = done_count;
    start_job(a, b, c);
    check({tag, " busy at start"}, busy, 1);
    check({tag, " err cleared"}, err, 0);
    wait_done(lat);
    check({tag, " latency"}, lat, LAT);
    check({tag, " err at done"}, err, fault ? 1 : 0);
    tick();
    check({tag, " done pulses"}, done_count - dn0, 1);
    check({tag, " reads"}, rd_count - rd0, 128);
    check({tag, " writes"}, wr_count - wr0, 128);
    check({tag, " busy after"}, busy, 0);
  endtask

  task automatic check_identity(input string tag, input logic [AW-1:0] c);
    for (int d = 0; d < 128; d++) begin
      logic [AW-1:0] addr;
      addr = c + AW'(d);
      check($sformatf("%s word %0d", tag, d), dst_mem[addr], {16'(2*d + 1), 16'(2*d)});
    end
  endtask

  task automatic check_const(input string tag, input logic [AW-1:0] c, input logic [31:0] exp);
    for (int d = 0; d < 128; d++) begin
      logic [AW-1:0] addr;
      addr = c + AW'(d);
      check($sformatf("%s word %0d", tag, d), dst_mem[addr], exp);
    end
  endtask

  task automatic check_ref(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] c);
    for (int d = 0; d < 128; d++) begin
      logic [AW-1:0] addr;
      addr = c + AW'(d);
      check($sformatf("%s word %0d", tag, d), dst_mem[addr], {ref_elem(a, b, 2*d + 1), ref_elem(a, b, 2*d)});
    end
  endtask

  task automatic abort_at(input string tag, input int cycle);
    int lat, rd0, wr0;
    clear_dst();
    fault5 = 1'b0;
    start_job(10'd0, 10'd64, 10'd300);
    lat = 1;
    while (lat < cycle) begin
      tick();
      lat++;
    end
    rd0 = rd_count; wr0 = wr_count;
    reset = 1'b1;
    tick();
    check({tag, " busy"}, busy, 0);
    check({tag, " src_en"}, src_en, 0);
    check({tag, " src_addr"}, src_addr, 0);
    check({tag, " dst_we"}, dst_we, 0);
    check({tag, " dst_wdata"}, dst_wdata, 0);
    check({tag, " core_valid"}, core_valid, 0);
    check({tag, " core_rst_n"}, core_rst_n, 0);
    reset = 1'b0;
    repeat (20) tick();
    check({tag, " no reads after"}, rd_count - rd0, 0);
    check({tag, " no writes after"}, wr_count - wr0, 0);
    check({tag, " idle after"}, busy, 0);
  endtask

  initial begin
    int lat, dn0;

    // Reset values
    repeat (3) tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst src_en", src_en, 0);
    check("rst src_addr", src_addr, 0);
    check("rst dst_we", dst_we, 0);
    check("rst dst_addr", dst_addr, 0);
    check("rst dst_wdata", dst_wdata, 0);
    check("rst core_valid", core_valid, 0);
    check("rst core_data", core_data, 0);
    check("rst core_rst_n", core_rst_n, 0);
    reset = 1'b0;
    tick();
    check("core_rst_n released", core_rst_n, 1);

    // Identity A times ramp B reproduces B
    fill(10'd0, 0);
    fill(10'd64, 1);
    run_job("ident", 10'd0, 10'd64, 10'd200, 1'b0);
    check_identity("ident", 10'd200);

    // All 0xFF operands: 16*65025 mod 65536 = 0xE010
    fill(10'd128, 2);
    fill(10'd192, 2);
    run_job("ovf", 10'd128, 10'd192, 10'd400, 1'b0);
    check_const("ovf", 10'd400, 32'hE010_E010);

    // Back-to-back with start held high
    clear_dst();
    dn0 = done_count;
    a_base = 10'd0; b_base = 10'd64; c_base = 10'd500;
    start = 1'b1;
    tick();
    check("b2b busy job1", busy, 1);
    a_base = 10'd128; b_base = 10'd192; c_base = 10'd700;
    wait_done(lat);
    check("b2b latency job1", lat, LAT);
    tick();
    check("b2b idle gap", busy, 0);
    tick();
    check("b2b busy job2", busy, 1);
    start = 1'b0;
    wait_done(lat);
    check("b2b latency job2", lat, LAT);
    tick();
    check("b2b done pulses", done_count - dn0, 2);
    check_identity("b2b job1", 10'd500);
    check_const("b2b job2", 10'd700, 32'hE010_E010);

    // Address wrap on A and on the result region
    fill(10'd1014, 3);
    fill(10'd300, 3);
    run_job("wrap", 10'd1014, 10'd300, 10'd1000, 1'b0);
    check_ref("wrap", 10'd1014, 10'd300, 10'd1000);

    // Aborts mid-LOAD and mid-DRAIN (drain index 40 is cycle 4227+40)
    fill(10'd0, 0);
    fill(10'd64, 1);
    abort_at("abort load", 50);
    abort_at("abort drain", 4267);
    run_job("post abort", 10'd0, 10'd64, 10'd600, 1'b0);
    check_identity("post abort", 10'd600);

    // Faulty core drops o_valid at pair 5: sticky err, cleared by the next start
    run_job("fault", 10'd0, 10'd64, 10'd800, 1'b1);
    repeat (3) tick();
    check("fault err sticky", err, 1);
    run_job("post fault", 10'd0, 10'd64, 10'd900, 1'b0);
    check_identity("post fault", 10'd900);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
